// File: rtl/mlp_inference_host.sv
// Purpose: drives one mlp_top inference per trigger and holds each result for a downstream consumer.
// Latency: trigger at T gives mlp_start at T+1; mlp_done seen at D gives result_valid at D+1.
// Backpressure: the result is held in PRESENT until result_ready; no watchdog runs while it waits.
module mlp_inference_host #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NUM_CLASSES    = 10,
  parameter int CLASS_W        = 4,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger,
  output logic               busy,
  output logic               mlp_start,
  input  logic               mlp_done,
  input  logic [CLASS_W-1:0] mlp_class,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CLASS_W-1:0] result_class,
  output logic               result_bad,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   infer_count
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]    WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CLASS_W:0]   NUM_CLASS_X = (CLASS_W + 1)'(NUM_CLASSES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_PRESENT
  } state_t;

  typedef struct packed {
    logic [CLASS_W-1:0] cls;
    logic               bad;
  } result_t;

  state_t            state;
  state_t            state_nxt;
  logic              arm;
  logic              capture;
  logic              expire;
  logic [WD_W-1:0]   wd_cnt;
  result_t           res_q;
  result_t           res_in;

  // Extra top bit keeps the out-of-range test correct when NUM_CLASSES == 2**CLASS_W.
  assign res_in.cls = mlp_class;
  assign res_in.bad = ({1'b0, mlp_class} >= NUM_CLASS_X);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    arm          = 1'b0;
    capture      = 1'b0;
    expire       = 1'b0;
    busy         = 1'b1;
    mlp_start    = 1'b0;
    result_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (trigger) begin
          arm       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        mlp_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A completion arriving in the expiry cycle still counts as a result.
        if (mlp_done) begin
          capture   = 1'b1;
          state_nxt = S_PRESENT;
        end else if (wd_cnt == WD_LAST) begin
          expire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_PRESENT: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt      <= '0;
      res_q       <= '0;
      timeout_err <= 1'b0;
      infer_count <= '0;
    end else begin
      if (arm) begin
        wd_cnt      <= '0;
        timeout_err <= 1'b0;
      end else if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (capture) begin
        res_q       <= res_in;
        infer_count <= infer_count + CNT_W'(1);
      end
      if (expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign result_class = res_q.cls;
  assign result_bad   = res_q.bad;

endmodule
